// File: rtl/vid_timing_pkg.sv
// Shared definitions for the video timing generator: region state encoding,
// 640x480 default timing constants, colour-bar levels and small helpers.
package vid_timing_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FP     = 2'd1,
      SYNC   = 2'd2,
      BP     = 2'd3
   } regionState_t;

   localparam int cDEF_HACTIVE = 640;
   localparam int cDEF_HFP     = 16;
   localparam int cDEF_HSYNC   = 96;
   localparam int cDEF_HBP     = 48;
   localparam int cDEF_VACTIVE = 480;
   localparam int cDEF_VFP     = 10;
   localparam int cDEF_VSYNC   = 2;
   localparam int cDEF_VBP     = 33;

   localparam logic [23:0] cBAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] cBAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] cBAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] cBAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] cBAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] cBAR_RED     = 24'hFF0000;
   localparam logic [23:0] cBAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] cBAR_BLACK   = 24'h000000;

   // Largest of four region lengths, used to size a region counter.
   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Counter width for a given longest region; never narrower than one bit.
   function automatic int cntWidth(input int maxLen);
      int w;
      w = $clog2(maxLen);
      if (w < 1) w = 1;
      return w;
   endfunction

   // Colour of bar number idx, left (white) to right (black).
   function automatic logic [23:0] barColor(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = cBAR_WHITE;
         3'd1:    c = cBAR_YELLOW;
         3'd2:    c = cBAR_CYAN;
         3'd3:    c = cBAR_GREEN;
         3'd4:    c = cBAR_MAGENTA;
         3'd5:    c = cBAR_RED;
         3'd6:    c = cBAR_BLUE;
         default: c = cBAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// One region state machine (ACTIVE -> FP -> SYNC -> BP -> ACTIVE) with its
// in-region counter. Advances only on iSTEP; oWRAP flags the BP -> ACTIVE step.
module vid_timing_cnt
   import vid_timing_pkg::*;
#(
   parameter int pCNTW = 2
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iSTEP,
   input  logic [pCNTW:0]     iLEN_ACTIVE,
   input  logic [pCNTW:0]     iLEN_FP,
   input  logic [pCNTW:0]     iLEN_SYNC,
   input  logic [pCNTW:0]     iLEN_BP,
   output regionState_t       oSTATE,
   output logic [pCNTW-1:0]   oCOUNT,
   output logic               oWRAP
);

   regionState_t       stateR;
   regionState_t       nextStateS;
   logic [pCNTW-1:0]   countR;
   logic [pCNTW:0]     curLenS;
   logic               lastS;

   // Length and successor of the current region; detect its final count.
   always_comb begin
      curLenS    = iLEN_ACTIVE;
      nextStateS = FP;
      case (stateR)
         ACTIVE: begin curLenS = iLEN_ACTIVE; nextStateS = FP;     end
         FP:     begin curLenS = iLEN_FP;     nextStateS = SYNC;   end
         SYNC:   begin curLenS = iLEN_SYNC;   nextStateS = BP;     end
         BP:     begin curLenS = iLEN_BP;     nextStateS = ACTIVE; end
         default: begin curLenS = iLEN_ACTIVE; nextStateS = ACTIVE; end
      endcase
      lastS = ({1'b0, countR} == (curLenS - (pCNTW+1)'(1)));
   end

   // Region state and counter; counter restarts at zero on every region entry.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         stateR <= ACTIVE;
         countR <= '0;
      end else if (iSTEP) begin
         if (lastS) begin
            stateR <= nextStateS;
            countR <= '0;
         end else begin
            countR <= countR + pCNTW'(1);
         end
      end else begin
         stateR <= stateR;
         countR <= countR;
      end
   end

   assign oSTATE = stateR;
   assign oCOUNT = countR;
   assign oWRAP  = iSTEP && lastS && (stateR == BP);

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator: horizontal/vertical region FSMs, pixel stream
// acceptance, registered sync/blank/RGB outputs, sticky underflow flag.
// Optional build macro VTG_TEST_PATTERN_EN adds iPATTERN and colour bars.
module vid_timing_gen
   import vid_timing_pkg::*;
#(
   parameter int   pHACTIVE = cDEF_HACTIVE,
   parameter int   pHFP     = cDEF_HFP,
   parameter int   pHSYNC   = cDEF_HSYNC,
   parameter int   pHBP     = cDEF_HBP,
   parameter int   pVACTIVE = cDEF_VACTIVE,
   parameter int   pVFP     = cDEF_VFP,
   parameter int   pVSYNC   = cDEF_VSYNC,
   parameter int   pVBP     = cDEF_VBP,
   parameter logic pHS_POL  = 1'b0,
   parameter logic pVS_POL  = 1'b0
) (
   input  logic        iCLK,
   input  logic        iRESET,
`ifdef VTG_TEST_PATTERN_EN
   input  logic        iPATTERN,
`endif
   input  logic [23:0] iPIX_DATA,
   input  logic        iPIX_VALID,
   output logic        oPIX_READY,
   input  logic        iUNDERFLOW_CLR,
   output logic [1:0]  oCTL,
   output logic        oBLANK,
   output logic [7:0]  oRED,
   output logic [7:0]  oGREEN,
   output logic [7:0]  oBLUE,
   output logic        oSOF,
   output logic        oUNDERFLOW
);

   localparam int cHCW = cntWidth(maxOf4(pHACTIVE, pHFP, pHSYNC, pHBP));
   localparam int cVCW = cntWidth(maxOf4(pVACTIVE, pVFP, pVSYNC, pVBP));

   localparam logic [cHCW:0] cHLEN_ACTIVE = (cHCW+1)'(pHACTIVE);
   localparam logic [cHCW:0] cHLEN_FP     = (cHCW+1)'(pHFP);
   localparam logic [cHCW:0] cHLEN_SYNC   = (cHCW+1)'(pHSYNC);
   localparam logic [cHCW:0] cHLEN_BP     = (cHCW+1)'(pHBP);
   localparam logic [cVCW:0] cVLEN_ACTIVE = (cVCW+1)'(pVACTIVE);
   localparam logic [cVCW:0] cVLEN_FP     = (cVCW+1)'(pVFP);
   localparam logic [cVCW:0] cVLEN_SYNC   = (cVCW+1)'(pVSYNC);
   localparam logic [cVCW:0] cVLEN_BP     = (cVCW+1)'(pVBP);

   regionState_t      hStateS;
   regionState_t      vStateS;
   logic [cHCW-1:0]   hCountS;
   logic [cVCW-1:0]   vCountS;
   logic              hWrapS;
   logic              unusedVWrapS;
   logic              activeS;
   logic              readyS;
   logic [23:0]       rgbR;

   vid_timing_cnt #(.pCNTW(cHCW)) uHTimer (
      .iCLK        (iCLK),
      .iRESET      (iRESET),
      .iSTEP       (1'b1),
      .iLEN_ACTIVE (cHLEN_ACTIVE),
      .iLEN_FP     (cHLEN_FP),
      .iLEN_SYNC   (cHLEN_SYNC),
      .iLEN_BP     (cHLEN_BP),
      .oSTATE      (hStateS),
      .oCOUNT      (hCountS),
      .oWRAP       (hWrapS)
   );

   // Lines advance only at the end of each horizontal line.
   vid_timing_cnt #(.pCNTW(cVCW)) uVTimer (
      .iCLK        (iCLK),
      .iRESET      (iRESET),
      .iSTEP       (hWrapS),
      .iLEN_ACTIVE (cVLEN_ACTIVE),
      .iLEN_FP     (cVLEN_FP),
      .iLEN_SYNC   (cVLEN_SYNC),
      .iLEN_BP     (cVLEN_BP),
      .oSTATE      (vStateS),
      .oCOUNT      (vCountS),
      .oWRAP       (unusedVWrapS)
   );

   assign activeS = (hStateS == ACTIVE) && (vStateS == ACTIVE);

`ifdef VTG_TEST_PATTERN_EN
   localparam int cBAR_W = pHACTIVE / 8;
   logic [cHCW-1:0] barQuotS;
   assign barQuotS = hCountS / cHCW'(cBAR_W);
   assign readyS   = activeS && !iRESET && !iPATTERN;
`else
   assign readyS   = activeS && !iRESET;
`endif

   assign oPIX_READY = readyS;

   // Registered video outputs, one cycle behind the FSM position they describe.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oBLANK     <= 1'b1;
         oCTL       <= {~pVS_POL, ~pHS_POL};
         rgbR       <= 24'h000000;
         oSOF       <= 1'b0;
         oUNDERFLOW <= 1'b0;
      end else begin
         oBLANK  <= ~activeS;
         oCTL[0] <= (hStateS == SYNC) ? pHS_POL : ~pHS_POL;
         oCTL[1] <= (vStateS == SYNC) ? pVS_POL : ~pVS_POL;
         oSOF    <= activeS && (hCountS == '0) && (vCountS == '0);
`ifdef VTG_TEST_PATTERN_EN
         if (iPATTERN) begin
            rgbR       <= activeS ? barColor(barQuotS[2:0]) : 24'h000000;
            oUNDERFLOW <= oUNDERFLOW & ~iUNDERFLOW_CLR;
         end else begin
            rgbR       <= (readyS && iPIX_VALID) ? iPIX_DATA : 24'h000000;
            oUNDERFLOW <= (readyS & ~iPIX_VALID) | (oUNDERFLOW & ~iUNDERFLOW_CLR);
         end
`else
         // A missing pixel goes out black; set wins over a same-cycle clear.
         rgbR       <= (readyS && iPIX_VALID) ? iPIX_DATA : 24'h000000;
         oUNDERFLOW <= (readyS & ~iPIX_VALID) | (oUNDERFLOW & ~iUNDERFLOW_CLR);
`endif
      end
   end

   assign oRED   = rgbR[23:16];
   assign oGREEN = rgbR[15:8];
   assign oBLUE  = rgbR[7:0];

endmodule
